sdram_port_arbiter: RTL

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_arb_pkg.sv | 17 +
 rtl/sdram_port_arbiter_rr_pick.sv | 38 +++
 rtl/sdram_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the SDRAM port arbiter.
//   arb_state_t      : arbiter FSM states (IDLE, ISSUE, WAIT_RD, DONE)
//   ARB_AW_DEF       : default SDRAM word address width
//   ARB_LOCK_MAX_DEF : default maximum back-to-back locked transactions
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam int ARB_AW_DEF       = 23;
  localparam int ARB_LOCK_MAX_DEF = 8;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// rr_pick: purely combinational round-robin selector.
//   req   : per-requester request bits (NREQ = 1..4)
//   last  : index of the previous winner; the search starts at last+1
//   grant : index of the selected requester (zero-extended to 2 bits)
//   valid : at least one request is present
module rr_pick
  import sdram_arb_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      grant,
  output logic            valid
);

  logic [3:0] req4;
  logic [2:0] cand;

  // Candidates are scanned from furthest to nearest so the requester
  // closest after 'last' is the final (winning) assignment.
  always_comb begin
    req4             = '0;
    req4[NREQ-1:0]   = req;
    grant            = '0;
    valid            = 1'b0;
    cand             = '0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = {1'b0, last} + 3'(i);
      if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
      if (req4[cand[1:0]]) begin
        grant = cand[1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM controller command port between
// NREQ requesters (0 = core0, 1 = core1, 2 = DMA) with round-robin
// arbitration and a single outstanding transaction.
//   sysclk, sysrst          : clock, synchronous active-high reset
//   m_req/m_we/m_lock       : per-requester request, write flag, lock request
//   m_addr/m_wdata/m_be     : packed per-requester address, write data, byte enables
//   m_ack                   : one-cycle completion pulse to the owner
//   m_rdata                 : read data, valid with the m_ack of a read, held after
//   s_valid/s_we/s_addr/s_wdata/s_be, s_ready : command handshake to the controller
//   s_rvalid/s_rdata        : read return, one beat per read
//   owner                   : current grant index (debug)
// Optional feature: define SDRAM_ARB_LOCK_EN to let an owner holding m_lock
// keep the port for up to LOCK_MAX back-to-back transactions.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int AW       = ARB_AW_DEF,
  parameter int LOCK_MAX = ARB_LOCK_MAX_DEF
) (
  input  logic                 sysclk,
  input  logic                 sysrst,
  input  logic [NREQ-1:0]      m_req,
  input  logic [NREQ-1:0]      m_we,
  input  logic [NREQ-1:0]      m_lock,
  input  logic [NREQ*AW-1:0]   m_addr,
  input  logic [NREQ*32-1:0]   m_wdata,
  input  logic [NREQ*4-1:0]    m_be,
  output logic [NREQ-1:0]      m_ack,
  output logic [31:0]          m_rdata,
  output logic                 s_valid,
  output logic                 s_we,
  output logic [AW-1:0]        s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_be,
  input  logic                 s_ready,
  input  logic                 s_rvalid,
  input  logic [31:0]          s_rdata,
  output logic [1:0]           owner
);

  arb_state_t      state;
  logic [1:0]      last_owner;
  logic [1:0]      pick;
  logic            pick_valid;
  logic            arb_take;
  logic            lock_take;
  logic [1:0]      sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [31:0]     sel_wdata;
  logic [3:0]      sel_be;
  logic [NREQ-1:0] ack_vec;

  function automatic logic [NREQ-1:0] onehot(input logic [1:0] idx);
    logic [NREQ-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++)
      if (idx == 2'(i)) r[i] = 1'b1;
    return r;
  endfunction

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (m_req),
    .last  (last_owner),
    .grant (pick),
    .valid (pick_valid)
  );

  assign arb_take = (state == IDLE) && pick_valid;
  assign ack_vec  = onehot(owner);

  // In IDLE the fields come from the arbitration winner; in DONE (lock
  // continuation) they are re-latched from the current owner.
  always_comb begin
    sel       = (state == IDLE) ? pick : owner;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == 2'(i)) begin
        sel_we    = m_we[i];
        sel_addr  = m_addr[i*AW +: AW];
        sel_wdata = m_wdata[i*32 +: 32];
        sel_be    = m_be[i*4 +: 4];
      end
    end
  end

`ifdef SDRAM_ARB_LOCK_EN
  localparam int LCW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;

  logic [LCW-1:0] lock_cnt;
  logic           own_lock;
  logic           own_req;

  always_comb begin
    own_lock = 1'b0;
    own_req  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == 2'(i)) begin
        own_lock = m_lock[i];
        own_req  = m_req[i];
      end
    end
  end

  // lock_cnt counts continuations after the arbitrated grant, so the owner
  // gets at most LOCK_MAX transactions in a row.
  assign lock_take = (state == DONE) && own_lock && own_req &&
                     (int'(lock_cnt) < LOCK_MAX - 1);

  always_ff @(posedge sysclk) begin
    if (sysrst)         lock_cnt <= '0;
    else if (arb_take)  lock_cnt <= '0;
    else if (lock_take) lock_cnt <= lock_cnt + 1'b1;
  end
`else
  logic unused_lock;
  assign unused_lock = ^m_lock;
  assign lock_take   = 1'b0;
`endif

  always_ff @(posedge sysclk) begin
    if (sysrst) begin
      state      <= IDLE;
      s_valid    <= 1'b0;
      m_ack      <= '0;
      m_rdata    <= '0;
      owner      <= '0;
      last_owner <= 2'(NREQ - 1);
    end else begin
      m_ack <= '0;
      case (state)
        IDLE: begin
          if (arb_take) begin
            owner      <= pick;
            last_owner <= pick;
            s_valid    <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          // Requester dropping m_req here does not abort the command.
          if (s_ready) begin
            s_valid <= 1'b0;
            if (s_we) begin
              m_ack <= ack_vec;
              state <= DONE;
            end else begin
              state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (s_rvalid) begin
            m_rdata <= s_rdata;
            m_ack   <= ack_vec;
            state   <= DONE;
          end
        end
        DONE: begin
          if (lock_take) begin
            s_valid <= 1'b1;
            state   <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command fields only load when a command is being set up, so they stay
  // stable for the whole ISSUE phase.
  always_ff @(posedge sysclk) begin
    if (arb_take || lock_take) begin
      s_we    <= sel_we;
      s_addr  <= sel_addr;
      s_wdata <= sel_wdata;
      s_be    <= sel_be;
    end
  end

endmodule
